// File: rtl/hms_sort_checker.sv
// hms_sort_checker
//   Checks the merge-network output stream of the merge sorter. Every run of
//   run_len beats must be non-decreasing by key, within a beat (lane 0 holds
//   the smallest key) and across consecutive beats of the same run. The first
//   violation is latched with its global beat index and lowest offending lane.
//   done rises once n_runs runs have passed without error.
//
//   Optional build macro HMS_CHK_SEQ_EN: adds an exact-sequence check. Each
//   lane key must equal exp_base+lane. exp_base starts at 1 and advances by
//   the number of lanes per accepted beat.
//
// Ports
//   CLK, RST     clock, asynchronous active-high reset
//   start        pulse: sample run_len/n_runs, clear status, enter RUN
//   run_len      beats per sorted run
//   n_runs       number of runs to check
//   din, dinen   record beat (lane i = din[DATW*i +: DATW]) and its valid
//   busy         checking in progress
//   done         all runs passed (held until next start)
//   err          violation seen (held until next start)
//   err_beat     global beat index of the first violation
//   err_lane     lowest offending lane of the first violation
//   beat_cnt     beats accepted since start
module hms_sort_checker #(
  parameter int E_LOG = 2,
  parameter int DATW  = 64,
  parameter int KEYW  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [31:0]              run_len,
  input  logic [31:0]              n_runs,
  input  logic [(DATW<<E_LOG)-1:0] din,
  input  logic                     dinen,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [31:0]              err_beat,
  output logic [E_LOG-1:0]         err_lane,
  output logic [31:0]              beat_cnt
);

  localparam int LANES = 1 << E_LOG;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t            state;
  state_t            state_nx;

  logic [31:0]       run_len_q;
  logic [31:0]       n_runs_q;
  logic [31:0]       beat_in_run;
  logic [31:0]       run_idx;
  logic [KEYW-1:0]   prev_key;

  logic [KEYW-1:0]   key [LANES];
  logic              inter_bad;
  logic              intra_bad;
  logic [E_LOG-1:0]  intra_lane;
  logic              ord_bad;
  logic [E_LOG-1:0]  ord_lane;
  logic              bad;
  logic [E_LOG-1:0]  bad_lane;
  logic              accept;
  logic              run_end;
  logic              last_beat;

  // Record payload above the key is not inspected.
  logic              unused_payload;
  assign unused_payload = ^din;

  assign accept    = (state == S_RUN) && dinen && !start;
  assign run_end   = (beat_in_run == run_len_q - 32'd1);
  assign last_beat = run_end && (run_idx == n_runs_q - 32'd1);

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      key[i] = din[DATW*i +: KEYW];
    end
  end

  // Ordering checks; the inter-beat check is skipped on the first beat of a run.
  always_comb begin
    inter_bad  = (beat_in_run != '0) && (prev_key > key[0]);
    intra_bad  = 1'b0;
    intra_lane = '0;
    // Scan downward so the lowest offending pair wins.
    for (int unsigned i = LANES - 1; i > 0; i--) begin
      if (key[i-1] > key[i]) begin
        intra_bad  = 1'b1;
        intra_lane = E_LOG'(i);
      end
    end
    ord_bad  = inter_bad || intra_bad;
    ord_lane = inter_bad ? '0 : intra_lane;
  end

`ifdef HMS_CHK_SEQ_EN
  logic [KEYW-1:0]   exp_base;
  logic              seq_bad;
  logic [E_LOG-1:0]  seq_lane;

  always_comb begin
    seq_bad  = 1'b0;
    seq_lane = '0;
    for (int unsigned i = LANES - 1; i < LANES; i--) begin
      if (key[i] != exp_base + KEYW'(i)) begin
        seq_bad  = 1'b1;
        seq_lane = E_LOG'(i);
      end
    end
    bad      = ord_bad || seq_bad;
    bad_lane = (seq_bad && (!ord_bad || (seq_lane < ord_lane))) ? seq_lane : ord_lane;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_base <= '0;
    end else if (start) begin
      exp_base <= KEYW'(1);
    end else if (accept) begin
      exp_base <= exp_base + KEYW'(LANES);
    end
  end
`else
  always_comb begin
    bad      = ord_bad;
    bad_lane = ord_lane;
  end
`endif

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ((run_len == '0) || (n_runs == '0)) ? S_DONE : S_RUN;
    end else if (accept) begin
      if (bad) begin
        state_nx = S_ERR;
      end else if (last_beat) begin
        state_nx = S_DONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_len_q   <= '0;
      n_runs_q    <= '0;
      beat_in_run <= '0;
      run_idx     <= '0;
      beat_cnt    <= '0;
      prev_key    <= '0;
      err_beat    <= '0;
      err_lane    <= '0;
    end else if (start) begin
      run_len_q   <= run_len;
      n_runs_q    <= n_runs;
      beat_in_run <= '0;
      run_idx     <= '0;
      beat_cnt    <= '0;
      prev_key    <= '0;
      err_beat    <= '0;
      err_lane    <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 32'd1;
      prev_key <= key[LANES-1];
      if (run_end) begin
        beat_in_run <= '0;
        run_idx     <= run_idx + 32'd1;
      end else begin
        beat_in_run <= beat_in_run + 32'd1;
      end
      if (bad) begin
        err_beat <= beat_cnt;
        err_lane <= bad_lane;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

endmodule

// File: tb/tb_hms_sort_checker.sv
module tb_hms_sort_checker;

  localparam int E_LOG = 2;
  localparam int DATW  = 64;
  localparam int KEYW  = 32;

  logic              CLK;
  logic              RST;
  logic              start;
  logic [31:0]       run_len;
  logic [31:0]       n_runs;
  logic [255:0]      din;
  logic              dinen;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       err_beat;
  logic [E_LOG-1:0]  err_lane;
  logic [31:0]       beat_cnt;

  hms_sort_checker #(.E_LOG(E_LOG), .DATW(DATW), .KEYW(KEYW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .run_len  (run_len),
    .n_runs   (n_runs),
    .din      (din),
    .dinen    (dinen),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_beat (err_beat),
    .err_lane (err_lane),
    .beat_cnt (beat_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: job-level view, run position from a global beat index.
  bit          m_busy, m_done, m_err;
  int unsigned m_cnt, m_eb, m_el;
  longint unsigned m_pos, m_rl, m_nr;
  int unsigned m_prev, m_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0;
    m_cnt = 0; m_eb = 0; m_el = 0; m_pos = 0;
    m_rl = 0; m_nr = 0; m_prev = 0; m_exp = 0;
  endtask

  task automatic model_start(input int unsigned rl, input int unsigned nr);
    m_cnt = 0; m_eb = 0; m_el = 0; m_pos = 0; m_prev = 0; m_exp = 1;
    m_rl = rl; m_nr = nr; m_err = 0;
    if (rl == 0 || nr == 0) begin
      m_busy = 0; m_done = 1;
    end else begin
      m_busy = 1; m_done = 0;
    end
  endtask

  task automatic model_beat(input int unsigned k0, k1, k2, k3);
    int unsigned k[4];
    int lane;
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    if (!m_busy) return;
    lane = -1;
    if ((m_pos % m_rl) != 0 && m_prev > k[0]) lane = 0;
    else
      for (int i = 1; i < 4; i++)
        if (lane < 0 && k[i-1] > k[i]) lane = i;
`ifdef HMS_CHK_SEQ_EN
    for (int i = 0; i < 4; i++)
      if (k[i] != m_exp + i) begin
        if (lane < 0 || i < lane) lane = i;
        break;
      end
    m_exp += 4;
`endif
    if (lane >= 0) begin
      m_err = 1; m_busy = 0; m_eb = m_cnt; m_el = lane;
    end else if (m_pos + 1 == m_rl * m_nr) begin
      m_done = 1; m_busy = 0;
    end
    m_prev = k[3];
    m_pos++;
    m_cnt++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},     32'(busy),     32'(m_busy));
    chk({tag, ".done"},     32'(done),     32'(m_done));
    chk({tag, ".err"},      32'(err),      32'(m_err));
    chk({tag, ".err_beat"}, err_beat,      m_eb);
    chk({tag, ".err_lane"}, 32'(err_lane), m_el);
    chk({tag, ".beat_cnt"}, beat_cnt,      m_cnt);
  endtask

  task automatic put_keys(input int unsigned k0, k1, k2, k3);
    int unsigned k[4];
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    for (int i = 0; i < 4; i++) begin
      din[64*i +: 32]    = k[i];
      din[64*i+32 +: 32] = $urandom;
    end
  endtask

  task automatic do_start(input string tag, input int unsigned rl, input int unsigned nr);
    @(negedge CLK);
    start = 1'b1; dinen = 1'b0; run_len = rl; n_runs = nr;
    @(posedge CLK);
    model_start(rl, nr);
    #1 check_all(tag);
  endtask

  task automatic beat(input string tag, input int unsigned k0, k1, k2, k3);
    @(negedge CLK);
    start = 1'b0; dinen = 1'b1;
    put_keys(k0, k1, k2, k3);
    @(posedge CLK);
    model_beat(k0, k1, k2, k3);
    #1 check_all(tag);
  endtask

  task automatic idle(input string tag);
    @(negedge CLK);
    start = 1'b0; dinen = 1'b0;
    @(posedge CLK);
    #1 check_all(tag);
  endtask

  task automatic clean_run(input string tag);
    do_start(tag, 4, 2);
    for (int unsigned b = 0; b < 8; b++)
      beat(tag, 4*b+1, 4*b+2, 4*b+3, 4*b+4);
    idle(tag);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; dinen = 1'b0; run_len = '0; n_runs = '0; din = '0;
    model_reset();
    #12;
    check_all("reset");
    RST = 1'b0;
    idle("idle");
    beat("idle_beat", 1, 2, 3, 4);
    beat("idle_beat", 5, 6, 7, 8);

    clean_run("clean");

    do_start("boundary", 2, 2);
    beat("boundary", 1, 2, 3, 4);
    beat("boundary", 5, 6, 7, 8);
    beat("boundary", 1, 2, 3, 4);
    beat("boundary", 5, 6, 7, 8);

    do_start("intra", 4, 2);
    beat("intra", 1, 2, 3, 4);
    beat("intra", 5, 6, 7, 8);
    beat("intra", 9, 10, 11, 12);
    beat("intra", 13, 15, 14, 16);
    beat("intra_after", 17, 18, 19, 20);

    do_start("inter_final", 2, 1);
    beat("inter_final", 5, 6, 7, 8);
    beat("inter_final", 7, 9, 10, 11);

    do_start("seq", 4, 1);
    beat("seq", 1, 2, 3, 4);
    beat("seq", 5, 6, 8, 9);

    // Unsigned compare: high-bit key must sort above small key.
    do_start("unsigned", 2, 1);
    beat("unsigned", 32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 3);

    do_start("zero_len", 0, 3);
    do_start("zero_runs", 3, 0);

    // start with a beat in the same cycle: beat must be ignored.
    @(negedge CLK);
    start = 1'b1; dinen = 1'b1; run_len = 2; n_runs = 1;
    put_keys(9, 8, 7, 6);
    @(posedge CLK);
    model_start(2, 1);
    #1 check_all("start_and_beat");
    beat("restart", 1, 2, 3, 4);
    do_start("restart", 1, 1);
    beat("restart", 1, 2, 3, 4);

    // Asynchronous reset between edges.
    do_start("areset", 4, 1);
    beat("areset", 1, 2, 3, 4);
    beat("areset", 5, 6, 7, 8);
    #2 RST = 1'b1;
    model_reset();
    #1 check_all("areset_async");
    RST = 1'b0;
    clean_run("after_reset");

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      int unsigned rl, nr, cur, k[4];
      rl = $urandom_range(1, 4);
      nr = $urandom_range(1, 3);
      do_start("rnd_start", rl, nr);
      cur = 0;
      for (int unsigned b = 0; b < rl * nr + 1; b++) begin
        if ($urandom_range(0, 5) == 0) idle("rnd_idle");
        if (b % rl == 0) cur = $urandom_range(0, 60);
        for (int i = 0; i < 4; i++) begin
          cur = cur + $urandom_range(0, 2);
          k[i] = cur;
        end
        if ($urandom_range(0, 15) == 0) k[$urandom_range(0, 3)] = $urandom_range(0, 10);
        beat("rnd", k[0], k[1], k[2], k[3]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
